// File: rtl/calc_btn_pkg.sv
// Shared constants and FSM state type for the calculator button arbiter.
package calc_btn_pkg;

  localparam int N_BTN  = 5;
  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } arb_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, stable-count debounce, and a
// single-cycle pulse when the debounced level goes from released to pressed.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic             r_deb_d;
  logic [CNT_W-1:0] r_cnt;

  // Bring the raw asynchronous level into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb <= 1'b0;
      r_cnt <= '0;
    end else if (r_sync2 == r_deb) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_deb <= r_sync2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Delayed copy of the debounced level for press-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb_d <= 1'b0;
    end else begin
      r_deb_d <= r_deb;
    end
  end

  assign o_rise = r_deb & ~r_deb_d;

endmodule

// File: rtl/btn_cmd_arbiter.sv
// Debounces N_BTN buttons, latches presses as pending requests and issues
// them one at a time to the calculator core with round-robin fairness and
// an idle holdoff after every accepted command.
module btn_cmd_arbiter #(
  parameter int N_BTN           = calc_btn_pkg::N_BTN,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLDOFF_CYCLES  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_BTN-1:0]                btn,
  input  logic                            cmd_ready,
  input  logic                            clr_overrun,
  output logic                            cmd_valid,
  output logic [calc_btn_pkg::CODE_W-1:0] cmd_code,
  output logic [N_BTN-1:0]                pending,
  output logic [N_BTN-1:0]                overrun
);

  import calc_btn_pkg::*;

  localparam int               HO_W    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYCLES - 1);

  arb_state_t        r_state, w_state_next;
  logic              r_cmd_valid, w_valid_next;
  logic [CODE_W-1:0] r_cmd_code, w_code_next;
  logic [CODE_W-1:0] r_last_grant, w_last_next;
  logic [HO_W-1:0]   r_ho_cnt, w_ho_next;
  logic              w_accept;

  logic [N_BTN-1:0]  w_rise;
  logic [N_BTN-1:0]  r_pending, w_pend_next;
  logic [N_BTN-1:0]  r_overrun, w_ovr_next;
  logic [N_BTN-1:0]  w_clr;

  logic [CODE_W-1:0] w_idx;
  logic [CODE_W-1:0] w_pick;
  logic              w_found;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
      btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (btn[gi]),
        .o_rise (w_rise[gi])
      );

      // A press landing on the same edge as this channel's grant clear re-arms it.
      assign w_clr[gi]       = w_accept && (r_cmd_code == CODE_W'(gi));
      assign w_pend_next[gi] = w_rise[gi] | (r_pending[gi] & ~w_clr[gi]);
      assign w_ovr_next[gi]  = (w_rise[gi] & r_pending[gi] & ~w_clr[gi])
                             | (r_overrun[gi] & ~clr_overrun);
    end
  endgenerate

  // Round-robin pick: first pending channel after the last granted one.
  always_comb begin
    w_idx   = r_last_grant;
    w_pick  = '0;
    w_found = 1'b0;
    for (int k = 0; k < N_BTN; k++) begin
      w_idx = (w_idx == CODE_W'(N_BTN - 1)) ? '0 : w_idx + 1'b1;
      if (!w_found && r_pending[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Next-state and command outputs for the issue/handshake/holdoff sequence.
  always_comb begin
    w_state_next = r_state;
    w_valid_next = r_cmd_valid;
    w_code_next  = r_cmd_code;
    w_last_next  = r_last_grant;
    w_ho_next    = r_ho_cnt;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|r_pending) begin
          w_code_next  = w_pick;
          w_valid_next = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          w_accept     = 1'b1;
          w_last_next  = r_cmd_code;
          w_valid_next = 1'b0;
          w_ho_next    = '0;
          w_state_next = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        w_valid_next = 1'b0;
        if (r_ho_cnt == HO_LAST) begin
          w_ho_next    = '0;
          w_state_next = ST_IDLE;
        end else begin
          w_ho_next = r_ho_cnt + 1'b1;
        end
      end
      default: begin
        w_valid_next = 1'b0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state, registered command outputs and grant history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cmd_valid  <= 1'b0;
      r_cmd_code   <= '0;
      r_last_grant <= CODE_W'(N_BTN - 1);
      r_ho_cnt     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cmd_valid  <= w_valid_next;
      r_cmd_code   <= w_code_next;
      r_last_grant <= w_last_next;
      r_ho_cnt     <= w_ho_next;
    end
  end

  // Per-channel request and sticky lost-press flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_pending <= w_pend_next;
      r_overrun <= w_ovr_next;
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_code  = r_cmd_code;
  assign pending   = r_pending;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_btn_cmd_arbiter.sv
// Directed bench for btn_cmd_arbiter with a command scoreboard.
module tb_btn_cmd_arbiter;

  localparam int NB  = 5;
  localparam int DEB = 4;
  localparam int HO  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn;
  logic          cmd_ready;
  logic          clr_overrun;
  logic          cmd_valid;
  logic [2:0]    cmd_code;
  logic [NB-1:0] pending;
  logic [NB-1:0] overrun;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_push  = 0;
  int            n_hs    = 0;
  logic [31:0]   exp_q[$];

  always #5 clk = ~clk;

  btn_cmd_arbiter #(
    .N_BTN           (NB),
    .DEBOUNCE_CYCLES (DEB),
    .HOLDOFF_CYCLES  (HO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (btn),
    .cmd_ready   (cmd_ready),
    .clr_overrun (clr_overrun),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .pending     (pending),
    .overrun     (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [31:0] code);
    exp_q.push_back(code);
    n_push++;
  endtask

  // Inputs change 2 time units after the falling edge; outputs are read there too.
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Scoreboard monitor: a handshake is valid seen before an edge plus ready at that edge.
  logic       mon_prev_valid = 1'b0;
  logic [2:0] mon_prev_code  = 3'd0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev_valid = 1'b0;
    end else begin
      if (mon_prev_valid && cmd_ready) begin
        n_hs++;
        chk("sb_cmd_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("sb_cmd_code", 32'(mon_prev_code), exp_q.pop_front());
      end else if (mon_prev_valid) begin
        chk("hold_valid", 32'(cmd_valid), 32'd1);
        chk("hold_code", 32'(cmd_code), 32'(mon_prev_code));
      end
      mon_prev_valid = cmd_valid;
      mon_prev_code  = cmd_code;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    btn = '0; cmd_ready = 1'b1; clr_overrun = 1'b0; rst_n = 1'b0;
    repeat (3) step();
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_code", 32'(cmd_code), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    repeat (3) step();

    // Single press on channel 2: command visible after edge 7.
    push_cmd(32'd2);
    btn[2] = 1'b1;
    repeat (6) step();
    chk("t1_pend_e5", 32'(pending), 32'd0);
    step();
    chk("t1_pend_e6", 32'(pending), 32'h04);
    chk("t1_valid_e6", 32'(cmd_valid), 32'd0);
    step();
    chk("t1_valid_e7", 32'(cmd_valid), 32'd1);
    chk("t1_code_e7", 32'(cmd_code), 32'd2);
    step();
    chk("t1_pend_e8", 32'(pending), 32'd0);
    chk("t1_valid_e8", 32'(cmd_valid), 32'd0);
    btn[2] = 1'b0;
    repeat (15) step();
    chk("t1_cmd_count", 32'(n_hs), 32'(n_push));

    // Bouncing channel 1 never stays stable long enough.
    for (int c = 0; c < 20; c++) begin
      btn[1] = ((c / 2) % 2 == 0);
      step();
    end
    btn[1] = 1'b0;
    repeat (10) step();
    chk("t2_pending", 32'(pending), 32'd0);
    chk("t2_valid", 32'(cmd_valid), 32'd0);
    chk("t2_cmd_count", 32'(n_hs), 32'(n_push));

    // Reset restores channel 0 as first priority.
    rst_n = 1'b0;
    step();
    chk("rst2_valid", 32'(cmd_valid), 32'd0);
    rst_n = 1'b1;
    step();

    // Simultaneous presses on 0, 3, 4: round-robin order and holdoff spacing.
    push_cmd(32'd0); push_cmd(32'd3); push_cmd(32'd4);
    btn = 5'b11001;
    repeat (8) step();
    chk("t3_valid_first", 32'(cmd_valid), 32'd1);
    chk("t3_code_first", 32'(cmd_code), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t3_gap", 32'(cmd_valid), 32'(k % 6 == 0));
    end
    btn = '0;
    repeat (20) step();
    chk("t3_cmd_count", 32'(n_hs), 32'(n_push));
    // Grant channel 1, then 0 and 3 together must come out as 3 then 0.
    push_cmd(32'd1);
    btn[1] = 1'b1;
    repeat (12) step();
    btn[1] = 1'b0;
    repeat (10) step();
    push_cmd(32'd3); push_cmd(32'd0);
    btn = 5'b01001;
    repeat (20) step();
    btn = '0;
    repeat (10) step();
    chk("t3_rr_count", 32'(n_hs), 32'(n_push));

    // Stalled core: command held, second press is lost and flagged.
    cmd_ready = 1'b0;
    push_cmd(32'd1);
    btn[1] = 1'b1;
    repeat (8) step();
    chk("t4_valid", 32'(cmd_valid), 32'd1);
    chk("t4_code", 32'(cmd_code), 32'd1);
    for (int c = 0; c < 50; c++) begin
      btn[1] = !(c >= 10 && c < 20);
      step();
      chk("t4_hold", 32'({cmd_valid, cmd_code}), 32'h9);
    end
    chk("t4_pending", 32'(pending), 32'h02);
    chk("t4_overrun", 32'(overrun), 32'h02);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("t4_overrun_clr", 32'(overrun), 32'd0);
    btn[1] = 1'b0;
    repeat (10) step();
    // Press edge coincides with the grant clear: request survives, no overrun.
    push_cmd(32'd1);
    btn[1] = 1'b1;
    repeat (6) step();
    cmd_ready = 1'b1;
    step();
    chk("t4_setwins_pend", 32'(pending), 32'h02);
    chk("t4_setwins_ovr", 32'(overrun), 32'd0);
    chk("t4_setwins_valid", 32'(cmd_valid), 32'd0);
    repeat (10) step();
    chk("t4_cmd_count", 32'(n_hs), 32'(n_push));
    btn[1] = 1'b0;
    repeat (10) step();
    chk("t4_pend_end", 32'(pending), 32'd0);
    chk("t4_ovr_end", 32'(overrun), 32'd0);

    // Reset while a command is presented; held button is reissued once.
    cmd_ready = 1'b0;
    push_cmd(32'd4);
    btn[4] = 1'b1;
    repeat (8) step();
    chk("t5_valid", 32'(cmd_valid), 32'd1);
    chk("t5_code", 32'(cmd_code), 32'd4);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(cmd_valid), 32'd0);
    chk("t5_async_code", 32'(cmd_code), 32'd0);
    chk("t5_async_pend", 32'(pending), 32'd0);
    step();
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    repeat (7) step();
    chk("t5_valid_e6", 32'(cmd_valid), 32'd0);
    step();
    chk("t5_valid_e7", 32'(cmd_valid), 32'd1);
    chk("t5_code_e7", 32'(cmd_code), 32'd4);
    repeat (10) step();
    chk("t5_cmd_count", 32'(n_hs), 32'(n_push));
    btn = '0;
    repeat (10) step();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("total_cmds", 32'(n_hs), 32'(n_push));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
